// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with direct-load and auto-scan modes.
// Build option: define DECODER_ACTIVE_LOW_EN for active-low decode outputs.
module scan_decoder #(
  parameter int SEL_W = 3,
  parameter int DIV   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    load,
  input  logic [SEL_W-1:0]        sel,
  input  logic [SEL_W-1:0]        last,
  output logic [(2**SEL_W)-1:0]   d,
  output logic [SEL_W-1:0]        idx,
  output logic                    tick,
  output logic                    wrap
);

  localparam int OUT_W = 2 ** SEL_W;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

`ifdef DECODER_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] D_IDLE = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] D_POL  = {OUT_W{1'b1}};
`else
  localparam logic [OUT_W-1:0] D_IDLE = {OUT_W{1'b0}};
  localparam logic [OUT_W-1:0] D_POL  = {OUT_W{1'b0}};
`endif

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] dec_q, dec_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] r;
    r    = {OUT_W{1'b0}};
    r[i] = 1'b1;
    return r;
  endfunction

  // Next-state: index, prescaler and step pulses; d decodes the index taken at this edge.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    wrap_d = 1'b0;
    if (!en) begin
      idx_d = idx_q;
      cnt_d = cnt_q;
    end else if (!mode) begin
      cnt_d = {CNT_W{1'b0}};
      if (load) begin
        idx_d = sel;
      end else begin
        idx_d = idx_q;
      end
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = {CNT_W{1'b0}};
        tick_d = 1'b1;
        // An index above a lowered limit also wraps straight to 0.
        if (idx_q >= last) begin
          idx_d  = {SEL_W{1'b0}};
          wrap_d = 1'b1;
        end else begin
          idx_d  = idx_q + SEL_W'(1);
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (en) begin
      dec_d = onehot(idx_d) ^ D_POL;
    end else begin
      dec_d = D_IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= {SEL_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
      dec_q  <= D_IDLE;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      dec_q  <= dec_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
    end
  end

  assign d    = dec_q;
  assign idx  = idx_q;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Directed table-driven bench for scan_decoder (SEL_W=3, DIV=4); honours DECODER_ACTIVE_LOW_EN.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [2:0] sel = 3'd0, last = 3'd7;
  logic [7:0] d;
  logic [2:0] idx;
  logic       tick, wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en, mode, load;
    logic [2:0] sel, last;
    logic [7:0] exp_d;
    logic [2:0] exp_idx;
    logic       exp_tick, exp_wrap;
    string      name;
  } vec_t;

  vec_t vq[$];

  scan_decoder #(.SEL_W(3), .DIV(4)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .sel(sel), .last(last), .d(d), .idx(idx), .tick(tick), .wrap(wrap)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic logic [7:0] pol(input logic [7:0] x);
`ifdef DECODER_ACTIVE_LOW_EN
    return ~x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic e, input logic m, input logic l, input logic [2:0] s,
                      input logic [2:0] lst, input logic [2:0] ei, input logic et,
                      input logic ew, input string nm);
    vec_t v;
    logic [7:0] one;
    one       = 8'h01;
    v.en      = e;  v.mode = m; v.load = l; v.sel = s; v.last = lst;
    v.exp_idx = ei; v.exp_tick = et; v.exp_wrap = ew; v.name = nm;
    v.exp_d   = e ? pol(one << ei) : pol(8'h00);
    vq.push_back(v);
  endtask

  // n scan cycles that do not step the index.
  task automatic hold(input int n, input logic [2:0] lst, input logic [2:0] ei, input string nm);
    for (int k = 0; k < n; k++) push(1'b1, 1'b1, 1'b0, 3'd0, lst, ei, 1'b0, 1'b0, nm);
  endtask

  task automatic step(input logic [2:0] lst, input logic [2:0] ei, input logic ew, input string nm);
    push(1'b1, 1'b1, 1'b0, 3'd0, lst, ei, 1'b1, ew, nm);
  endtask

  initial begin
    // Direct mode, enable gating
    push(1'b1, 1'b0, 1'b1, 3'd5, 3'd7, 3'd5, 1'b0, 1'b0, "load5");
    push(1'b1, 1'b0, 1'b0, 3'd2, 3'd7, 3'd5, 1'b0, 1'b0, "hold5");
    push(1'b1, 1'b0, 1'b1, 3'd2, 3'd7, 3'd2, 1'b0, 1'b0, "load2");
    push(1'b0, 1'b0, 1'b1, 3'd6, 3'd7, 3'd2, 1'b0, 1'b0, "dis_load_ignored");
    push(1'b0, 1'b0, 1'b0, 3'd6, 3'd7, 3'd2, 1'b0, 1'b0, "dis_hold");
    push(1'b1, 1'b0, 1'b0, 3'd6, 3'd7, 3'd2, 1'b0, 1'b0, "reenable");
    push(1'b1, 1'b0, 1'b1, 3'd0, 3'd7, 3'd0, 1'b0, 1'b0, "load0");
    // Full frame 0..7 and wrap
    for (int s = 0; s < 8; s++) begin
      hold(3, 3'd7, 3'(s), "frame_hold");
      step(3'd7, 3'((s + 1) % 8), (s == 7), "frame_step");
    end
    // Advance to idx 5, then lower the limit
    for (int s = 0; s < 5; s++) begin
      hold(3, 3'd7, 3'(s), "to5_hold");
      step(3'd7, 3'(s + 1), 1'b0, "to5_step");
    end
    hold(3, 3'd2, 3'd5, "lowered_hold");
    step(3'd2, 3'd0, 1'b1, "lowered_wrap");
    for (int k = 0; k < 6; k++) begin
      hold(3, 3'd2, 3'(k % 3), "last2_hold");
      step(3'd2, 3'((k + 1) % 3), (k % 3 == 2), "last2_step");
    end
    // Freeze mid-step at idx 3, cnt 2
    for (int s = 0; s < 3; s++) begin
      hold(3, 3'd7, 3'(s), "to3_hold");
      step(3'd7, 3'(s + 1), 1'b0, "to3_step");
    end
    hold(2, 3'd7, 3'd3, "pre_freeze");
    for (int k = 0; k < 10; k++) push(1'b0, 1'b1, 1'b0, 3'd0, 3'd7, 3'd3, 1'b0, 1'b0, "freeze");
    hold(1, 3'd7, 3'd3, "unfreeze");
    step(3'd7, 3'd4, 1'b0, "unfreeze_step");
    // Scan -> direct clears prescaler; re-entering scan takes DIV cycles
    hold(2, 3'd7, 3'd4, "pre_direct");
    push(1'b1, 1'b0, 1'b0, 3'd0, 3'd7, 3'd4, 1'b0, 1'b0, "to_direct");
    hold(3, 3'd7, 3'd4, "rescan_hold");
    step(3'd7, 3'd5, 1'b0, "rescan_step");
    // Index above limit when entering scan
    push(1'b1, 1'b0, 1'b1, 3'd6, 3'd3, 3'd6, 1'b0, 1'b0, "load6");
    hold(3, 3'd3, 3'd6, "over_hold");
    step(3'd3, 3'd0, 1'b1, "over_wrap");
    // last = 0: every step ticks and wraps on 0
    for (int k = 0; k < 2; k++) begin
      hold(3, 3'd0, 3'd0, "last0_hold");
      step(3'd0, 3'd0, 1'b1, "last0_step");
    end

    // Bring registers out of X with one load, then async reset with the clock stopped
    en = 1'b1; mode = 1'b0; load = 1'b1; sel = 3'd5;
    clk_run = 1'b1;
    @(posedge clk); #1;
    clk_run = 1'b0;
    chk("preload.d", 32'(d), 32'(pol(8'h20)));
    #2 reset = 1'b1;
    #1;
    chk("async_reset.d", 32'(d), 32'(pol(8'h00)));
    chk("async_reset.idx", 32'(idx), 32'd0);
    chk("async_reset.tick", 32'(tick), 32'd0);
    chk("async_reset.wrap", 32'(wrap), 32'd0);
    en = 1'b0; load = 1'b0;
    #3 reset = 1'b0;
    #2;
    chk("release_no_edge.d", 32'(d), 32'(pol(8'h00)));
    clk_run = 1'b1;

    foreach (vq[i]) begin
      en = vq[i].en; mode = vq[i].mode; load = vq[i].load;
      sel = vq[i].sel; last = vq[i].last;
      @(posedge clk); #1;
      chk({vq[i].name, ".d"},    32'(d),    32'(vq[i].exp_d));
      chk({vq[i].name, ".idx"},  32'(idx),  32'(vq[i].exp_idx));
      chk({vq[i].name, ".tick"}, 32'(tick), 32'(vq[i].exp_tick));
      chk({vq[i].name, ".wrap"}, 32'(wrap), 32'(vq[i].exp_wrap));
    end

    // Reset mid-run while tick/wrap are high must clear them at once
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset.d", 32'(d), 32'(pol(8'h00)));
    chk("midrun_reset.tick", 32'(tick), 32'd0);
    chk("midrun_reset.wrap", 32'(wrap), 32'd0);
    chk("midrun_reset.idx", 32'(idx), 32'd0);
    en = 1'b1; mode = 1'b0; load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset.d", 32'(d), 32'(pol(8'h01)));
    chk("post_reset.idx", 32'(idx), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
